// File: rtl/fir_sample_serializer_if.sv
// Sample handshake between the FIR filter and the serial link transmitter.
//   sample_in     signed sample, valid when sample_valid is high
//   sample_valid  source has a sample this cycle
//   sample_ready  sink can take a sample; transfer when valid && ready
// master = sample source (filter), slave = serializer.
interface fir_sample_serializer_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic                     sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/fir_sample_serializer.sv
// Transmit end of the filter sample stream. Buffers samples in a small FIFO
// and sends each one MSB-first on a left-justified serial audio link, the same
// sample in the left and the right slot. bclk/lrclk are divided from clock.
// Ports:
//   clock       system clock, posedge
//   reset_n     asynchronous reset, active HIGH despite the name
//   s_if        sample handshake (slave side)
//   bclk        bit clock, period 2*CLK_DIV clocks
//   lrclk       0 = left slot, 1 = right slot
//   sdata       serial data, updated on bclk falling events
//   underrun    one-cycle pulse when a frame starts with the FIFO empty
//   fifo_level  FIFO occupancy 0..FIFO_DEPTH
//
// state | meaning
// IDLE  | link quiet, waiting for the first sample
// RUN   | frames running back to back until reset
module fir_sample_serializer #(
    parameter int DATA_W     = 16,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    fir_sample_serializer_if.slave        s_if,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(2 * DATA_W);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d, hold_q, hold_d;
    logic                bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
    logic                underrun_q, underrun_d;
    logic                push, pop, fifo_empty;
    logic [CNT_W-1:0]    bit_nxt;
    logic [DATA_W-1:0]   head;

    assign s_if.sample_ready = (level_q != LVL_W'(FIFO_DEPTH));
    assign push       = s_if.sample_valid && s_if.sample_ready;
    assign fifo_empty = (level_q == '0);
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        underrun_d = 1'b0;
        pop        = 1'b0;
        bit_nxt    = '0;
        case (state_q)
            IDLE: begin
                div_d     = '0;
                bclk_d    = 1'b0;
                bit_cnt_d = '0;
                if (!fifo_empty) begin
                    state_d = RUN;
                    pop     = 1'b1;
                    hold_d  = head;
                    shift_d = head;
                    sdata_d = head[DATA_W-1];
                    lrclk_d = 1'b0;
                end
            end
            default: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    // bclk high at terminal count: falling event, advance one bit
                    if (bclk_q) begin
                        bit_nxt   = (bit_cnt_q == CNT_W'(2 * DATA_W - 1)) ? '0 : bit_cnt_q + 1'b1;
                        bit_cnt_d = bit_nxt;
                        lrclk_d   = (bit_nxt >= CNT_W'(DATA_W));
                        if (bit_nxt == CNT_W'(DATA_W)) begin
                            // right slot repeats the sample from the hold copy
                            shift_d = hold_q;
                            sdata_d = hold_q[DATA_W-1];
                        end else if (bit_nxt == '0) begin
                            if (!fifo_empty) begin
                                pop     = 1'b1;
                                hold_d  = head;
                                shift_d = head;
                                sdata_d = head[DATA_W-1];
                            end else begin
                                hold_d     = '0;
                                shift_d    = '0;
                                sdata_d    = 1'b0;
                                underrun_d = 1'b1;
                            end
                        end else begin
                            shift_d = shift_q << 1;
                            sdata_d = shift_q[DATA_W-2];
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase

        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by level_q alone.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= s_if.sample_in;
    end

    assign bclk       = bclk_q;
    assign lrclk      = lrclk_q;
    assign sdata      = sdata_q;
    assign underrun   = underrun_q;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_fir_sample_serializer.sv
module tb_fir_sample_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_sample_serializer_if #(.DATA_W(16)) if1 ();
    fir_sample_serializer_if #(.DATA_W(16)) if2 ();

    logic bclk1, lrclk1, sdata1, ur1, bclk2, lrclk2, sdata2, ur2;
    logic [2:0] lvl1, lvl2;

    fir_sample_serializer #(.DATA_W(16), .CLK_DIV(4), .FIFO_DEPTH(4)) dut1 (
        .clock(clk), .reset_n(rst), .s_if(if1.slave),
        .bclk(bclk1), .lrclk(lrclk1), .sdata(sdata1), .underrun(ur1), .fifo_level(lvl1));

    fir_sample_serializer #(.DATA_W(16), .CLK_DIV(2), .FIFO_DEPTH(4)) dut2 (
        .clock(clk), .reset_n(rst), .s_if(if2.slave),
        .bclk(bclk2), .lrclk(lrclk2), .sdata(sdata2), .underrun(ur2), .fifo_level(lvl2));

    int n_pass = 0;
    int n_total = 0;

    // Checks one 32-bit frame starting right after the posedge that began it.
    task automatic check_frame(input bit sel, input logic [15:0] exp, input bit exp_ur, input string tag);
        int hp;
        hp = sel ? 2 : 4;
        for (int i = 0; i < 32; i++) begin
            logic eb, el, eu, s, l, b, u;
            int idx;
            idx = 15 - (i % 16);
            eb  = exp[idx];
            el  = (i >= 16);
            eu  = (i == 0) && exp_ur;
            @(negedge clk);
            s = sel ? sdata2 : sdata1; l = sel ? lrclk2 : lrclk1;
            b = sel ? bclk2 : bclk1;   u = sel ? ur2 : ur1;
            n_total++; if (s !== eb) $display("FAIL %s sdata bit %0d: got %b expected %b", tag, i, s, eb); else n_pass++;
            n_total++; if (l !== el) $display("FAIL %s lrclk bit %0d: got %b expected %b", tag, i, l, el); else n_pass++;
            n_total++; if (b !== 1'b0) $display("FAIL %s bclk low bit %0d: got %b expected 0", tag, i, b); else n_pass++;
            n_total++; if (u !== eu) $display("FAIL %s underrun bit %0d: got %b expected %b", tag, i, u, eu); else n_pass++;
            @(posedge clk); @(negedge clk);
            u = sel ? ur2 : ur1;
            n_total++; if (u !== 1'b0) $display("FAIL %s underrun width bit %0d: got %b expected 0", tag, i, u); else n_pass++;
            repeat (hp - 1) @(posedge clk);
            @(negedge clk);
            s = sel ? sdata2 : sdata1; b = sel ? bclk2 : bclk1;
            n_total++; if (b !== 1'b1) $display("FAIL %s bclk high bit %0d: got %b expected 1", tag, i, b); else n_pass++;
            n_total++; if (s !== eb) $display("FAIL %s sdata hold bit %0d: got %b expected %b", tag, i, s, eb); else n_pass++;
            repeat (hp) @(posedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++; if ({bclk1, lrclk1, sdata1, ur1} !== 4'b0) $display("FAIL reset outputs: got %b expected 0000", {bclk1, lrclk1, sdata1, ur1}); else n_pass++;
        n_total++; if (lvl1 !== 3'd0 || if1.sample_ready !== 1'b1) $display("FAIL reset level/ready: got %0d/%b expected 0/1", lvl1, if1.sample_ready); else n_pass++;
        @(negedge clk) rst = 1'b0;
        if1.sample_valid = 1'b1; if1.sample_in = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk) if1.sample_valid = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        n_total++; if (sdata1 !== 1'b1 || lvl1 !== 3'd1) $display("FAIL midframe before reset: got sdata %b level %0d expected 1/1", sdata1, lvl1); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if ({bclk1, lrclk1, sdata1, ur1} !== 4'b0) $display("FAIL midframe reset outputs: got %b expected 0000", {bclk1, lrclk1, sdata1, ur1}); else n_pass++;
        n_total++; if (lvl1 !== 3'd0 || if1.sample_ready !== 1'b1) $display("FAIL midframe reset level/ready: got %0d/%b expected 0/1", lvl1, if1.sample_ready); else n_pass++;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        if1.sample_valid = 1'b1; if1.sample_in = 16'hA5C3;
        @(posedge clk); #1;
        n_total++; if (lvl1 !== 3'd1 || sdata1 !== 1'b0) $display("FAIL single latency: got level %0d sdata %b expected 1/0", lvl1, sdata1); else n_pass++;
        @(negedge clk) if1.sample_valid = 1'b0;
        @(posedge clk);
        check_frame(1'b0, 16'hA5C3, 1'b0, "single");
    endtask

    task automatic test_underrun();
        check_frame(1'b0, 16'h0000, 1'b1, "underrun");
    endtask

    task automatic test_backpressure();
        logic [15:0] s [5];
        s[0] = 16'h1234; s[1] = 16'hFEDC; s[2] = 16'h0F0F; s[3] = 16'h8001; s[4] = 16'h7FFE;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if1.sample_valid = 1'b1; if1.sample_in = s[k];
            @(posedge clk);
        end
        @(negedge clk) if1.sample_in = s[4];
        n_total++; if (lvl1 !== 3'd4 || if1.sample_ready !== 1'b0) $display("FAIL bp full: got level %0d ready %b expected 4/0", lvl1, if1.sample_ready); else n_pass++;
        repeat (251) @(posedge clk);
        @(negedge clk);
        n_total++; if (lvl1 !== 3'd4 || if1.sample_ready !== 1'b0) $display("FAIL bp held: got level %0d ready %b expected 4/0", lvl1, if1.sample_ready); else n_pass++;
        @(posedge clk);
        fork
            check_frame(1'b0, s[0], 1'b0, "bp0");
            begin
                #1;
                n_total++; if (lvl1 !== 3'd3 || if1.sample_ready !== 1'b1) $display("FAIL bp after pop: got level %0d ready %b expected 3/1", lvl1, if1.sample_ready); else n_pass++;
                @(posedge clk); #1;
                n_total++; if (lvl1 !== 3'd4 || if1.sample_ready !== 1'b0) $display("FAIL bp fifth accepted: got level %0d ready %b expected 4/0", lvl1, if1.sample_ready); else n_pass++;
                if1.sample_valid = 1'b0;
            end
        join
        for (int k = 1; k < 5; k++) check_frame(1'b0, s[k], 1'b0, "bp");
    endtask

    task automatic test_ordering();
        fork
            begin
                check_frame(1'b0, 16'h0000, 1'b1, "order_ur");
                for (int k = 1; k <= 8; k++) check_frame(1'b0, 16'(k), 1'b0, "order");
            end
            begin
                for (int v = 1; v <= 8; v++) begin
                    logic acc;
                    int guard;
                    @(negedge clk);
                    if1.sample_valid = 1'b1; if1.sample_in = 16'(v);
                    acc = if1.sample_ready; guard = 0;
                    while (!acc && guard < 1000) begin
                        @(negedge clk);
                        acc = if1.sample_ready; guard++;
                    end
                    n_total++; if (acc !== 1'b1) $display("FAIL order feed %0d: got ready %b expected 1 within 1000 cycles", v, acc); else n_pass++;
                    @(posedge clk);
                end
                @(negedge clk) if1.sample_valid = 1'b0;
            end
        join
    endtask

    task automatic test_clkdiv2();
        @(negedge clk);
        if2.sample_valid = 1'b1; if2.sample_in = 16'h8000;
        @(posedge clk);
        @(negedge clk) if2.sample_valid = 1'b0;
        @(posedge clk);
        check_frame(1'b1, 16'h8000, 1'b0, "div2");
        check_frame(1'b1, 16'h0000, 1'b1, "div2_ur");
    endtask

    initial begin
        if1.sample_valid = 1'b0; if1.sample_in = '0;
        if2.sample_valid = 1'b0; if2.sample_in = '0;
        test_reset();
        test_single();
        test_underrun();
        test_backpressure();
        test_ordering();
        test_clkdiv2();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
